uart_rx_status: RTL and testbench
=================================

# uart_rx_status

UART receiver that pairs with the board's periodic status transmitter (8N1, LSB first). Recovers bytes from the serial line and decodes the status protocol: `"M"` (0x4D) means moving, `"S"` (0x53) means stopped. It also flags a stale status link when no valid status byte arrives within a timeout. It sits on the receiving FPGA/host-side fabric between the `rx` pin and the consumer logic (LED/display/controller).

## Interface
Parameters:
- `CLK_FREQ`, 100_000_000, system clock frequency in Hz
- `BAUD`, 115200, line rate; `DIV = CLK_FREQ/BAUD` (868 at defaults), `HALF = DIV/2` (434)
- `STATUS_TIMEOUT`, 25_000_000, cycles without an accepted status byte before `status_valid` drops (0.25 s, covers >2 missed 0.1 s sends)

Ports:
- `clk` in 1: system clock; single clock domain
- `rst_n` in 1: asynchronous, active-low reset
- `rx` in 1: asynchronous serial input, idle high
- `data` out 8: last received byte; reset 0x00; updated only on good frame
- `data_valid` out 1: 1-cycle pulse, `data` is new; reset 0
- `frame_err` out 1: 1-cycle pulse, stop bit sampled low; reset 0
- `moving` out 1: decoded status level; reset 0
- `status_valid` out 1: high while the status link is fresh; reset 0
- `busy` out 1: high in any state other than IDLE; reset 0

## Operation
- `rx` passes through a 2-FF synchronizer (reset value 1), giving `rx_s`; all logic uses `rx_s` only.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on `rx_s` falling edge (prev 1, now 0), go to START with `div_cnt=0`.
  - START: count to HALF-1, then sample `rx_s`. If 0, go to DATA with `bit_cnt=0` and `div_cnt=0`. If 1, treat as a glitch and return to IDLE with no output.
  - DATA: count to DIV-1, then sample into the shift register (LSB first) and increment `bit_cnt`. After the 8th sample, go to STOP.
  - STOP: count to DIV-1, then sample. If 1, load `data` and pulse `data_valid`. If 0, pulse `frame_err` and leave `data` unchanged. Either way, return to IDLE.
- Because IDLE requires a falling edge, a held-low line (break) after a framing error does not retrigger.
- Status decode runs on each `data_valid`:
  - 0x4D: `moving<=1`, `status_valid<=1`, timeout counter cleared.
  - 0x53: `moving<=0`, `status_valid<=1`, timeout counter cleared.
  - Any other byte: `data`/`data_valid` are still reported; `moving` and the timeout counter are unchanged.
- Timeout counter: 25-bit, free-running, saturating. When it reaches STATUS_TIMEOUT-1, `status_valid<=0`. `moving` holds its last value.
- `rst_n` low at any time, including mid-frame, forces every register to its reset value immediately. After release, reception restarts from IDLE on the next falling edge.

## Timing
- Let cycle t be the first cycle where `rx_s`=0 in IDLE. The pin-to-`rx_s` delay is 2 cycles.
- Sample points:
  - start bit: t+HALF
  - bit i: t+HALF+(i+1)·DIV
  - stop bit: t+HALF+9·DIV
- `data_valid`/`frame_err` are registered high in the cycle after the stop sample, for exactly 1 cycle.
- `moving`/`status_valid` update in the cycle after `data_valid`.
- Back-to-back frames: the next start edge can be detected from the cycle after the stop sample, so there is no dead time beyond the stop half-bit.
- `div_cnt` is 16 bits and `bit_cnt` is 4 bits, with no wrap within a frame. `DIV` must be ≥ 4, enforced by an elaboration-time check.

## Structure
- Shared package `uart_pkg`:
  - `uart_rx_state_t` enum (IDLE, START, DATA, STOP)
  - `STATUS_MOVING = 8'h4D` and `STATUS_STOPPED = 8'h53`, also used by the transmitter
  - function `uart_div(clk_freq, baud)`
- One sub-module, `sync_2ff` (parameterized reset value), for the `rx` synchronizer. FSM, datapath, decoder and timeout live in the top.

## Test plan
- Drive 8N1 frame 0x4D at 115200 baud (868-cycle bits) → one `data_valid` pulse, `data=0x4D`, `moving=1`, `status_valid=1`, at stop-sample + 1 cycle.
- Drive frame 0x53, then 0xA5 back-to-back with no idle gap → `data_valid` twice, `moving=0` after the first and unchanged after 0xA5, `data=0xA5` at the end.
- Drive frame 0x4D with the stop bit held low → `frame_err` 1-cycle pulse, no `data_valid`, `data` and `moving` unchanged; with `rx` held low afterwards, no further activity until `rx` returns high and falls again.
- Apply a 200-cycle low glitch on idle `rx` → START aborts at HALF; no pulses; `busy` returns to 0.
- With STATUS_TIMEOUT=1000 override, send 0x4D then idle for 1000 cycles → `status_valid` falls at exactly 1000 cycles after the `data_valid` cycle; `moving` stays 1.
- Assert `rst_n=0` during bit 4 of a frame → all outputs at reset values immediately; a subsequent clean 0x53 frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the status receiver and transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_rx_state_t;

    localparam logic [7:0] STATUS_MOVING  = 8'h4D;
    localparam logic [7:0] STATUS_STOPPED = 8'h53;

    // Clock cycles per bit period.
    function automatic int unsigned uart_div(input int unsigned clk_freq, input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_status.sv
// 8N1 UART receiver with moving/stopped status decode and stale-link timeout.
module uart_rx_status
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ       = 100_000_000,
    parameter int unsigned BAUD           = 115_200,
    parameter int unsigned STATUS_TIMEOUT = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_err,
    output logic       moving,
    output logic       status_valid,
    output logic       busy
);

    localparam int unsigned DIV   = uart_div(CLK_FREQ, BAUD);
    localparam int unsigned HALF  = DIV / 2;
    localparam int unsigned DIV_W = 16;
    localparam int unsigned BIT_W = 4;
    localparam int unsigned TO_W  = 25;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(HALF - 1);
    localparam logic [TO_W-1:0]  TO_MAX    = TO_W'(STATUS_TIMEOUT - 1);

    if (DIV < 4) begin : g_div_check
        $error("uart_rx_status: DIV must be at least 4");
    end
    if (DIV > 65536) begin : g_div_range
        $error("uart_rx_status: DIV does not fit the 16-bit bit counter");
    end
    if (STATUS_TIMEOUT < 2 || STATUS_TIMEOUT > 33_554_432) begin : g_to_range
        $error("uart_rx_status: STATUS_TIMEOUT out of range for the 25-bit counter");
    end

    logic rx_s;

    sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    uart_rx_state_t   state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             rx_prev_q;
    logic [7:0]       data_d;
    logic             data_valid_d;
    logic             frame_err_d;
    logic [TO_W-1:0]  to_cnt;

    // Frame FSM state and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            rx_prev_q  <= 1'b1;
            data       <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rx_prev_q  <= rx_s;
            data       <= data_d;
            data_valid <= data_valid_d;
            frame_err  <= frame_err_d;
            busy       <= (state_d != IDLE);
        end
    end

    // Next-state and datapath logic; samples land mid-bit via the half-bit start delay.
    always_comb begin
        state_d      = state_q;
        div_cnt_d    = div_cnt_q + DIV_W'(1);
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        data_d       = data;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        case (state_q)
            IDLE: begin
                div_cnt_d = '0;
                if (rx_prev_q && !rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (div_cnt_q == HALF_LAST) begin
                    div_cnt_d = '0;
                    if (!rx_s) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == BIT_W'(7)) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    state_d   = IDLE;
                    if (rx_s) begin
                        data_d       = shift_q;
                        data_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status decode and stale-link timeout; link goes stale as the counter lands on its limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            moving       <= 1'b0;
            status_valid <= 1'b0;
            to_cnt       <= '0;
        end else begin
            if (data_valid && (data == STATUS_MOVING || data == STATUS_STOPPED)) begin
                moving       <= (data == STATUS_MOVING);
                status_valid <= 1'b1;
                to_cnt       <= '0;
            end else if (to_cnt != TO_MAX) begin
                to_cnt <= to_cnt + TO_W'(1);
                if (to_cnt == TO_MAX - TO_W'(1)) begin
                    status_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_status.sv
// Bench for uart_rx_status: per-cycle event scoreboard, vector table and corner-case sequences.
module tb_uart_rx_status;

    localparam int CLK_FREQ = 6_400_000;
    localparam int BAUD     = 100_000;
    localparam int TMO      = 1000;
    localparam int DIV      = 64;
    localparam int HALF     = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_err;
    logic       moving;
    logic       status_valid;
    logic       busy;

    uart_rx_status #(
        .CLK_FREQ       (CLK_FREQ),
        .BAUD           (BAUD),
        .STATUS_TIMEOUT (TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx           (rx),
        .data         (data),
        .data_valid   (data_valid),
        .frame_err    (frame_err),
        .moving       (moving),
        .status_valid (status_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model: expected pulse cycles and status history derived from line timing.
    typedef struct {
        int         cyc;
        bit         ok;
        logic [7:0] b;
    } ev_t;

    ev_t        evq[$];
    ev_t        mon_ev;
    bit         mon_en = 1'b0;
    bit         win_valid = 1'b0;
    int         win_from = 0;
    int         win_to = 0;
    logic [7:0] m_data = 8'h00;
    bit         m_moving = 1'b0;
    bit         have_st = 1'b0;
    int         st_d = 0;
    int         last_d = 0;
    int         dv_cnt = 0;
    int         fe_cnt = 0;

    int         k;
    bit         e_dv;
    bit         e_fe;
    logic [7:0] e_data;
    bit         e_sv;
    bit         e_busy;

    always @(negedge clk) begin
        if (mon_en) begin
            k      = cyc;
            e_dv   = 1'b0;
            e_fe   = 1'b0;
            e_data = m_data;
            if (evq.size() > 0 && evq[0].cyc == k) begin
                mon_ev = evq.pop_front();
                if (mon_ev.ok) begin
                    e_dv   = 1'b1;
                    e_data = mon_ev.b;
                end else begin
                    e_fe = 1'b1;
                end
            end
            e_sv   = have_st && (k > st_d) && (k < st_d + TMO);
            e_busy = win_valid && (k >= win_from) && (k <= win_to);
            chk("data_valid", 32'(data_valid), 32'(e_dv));
            chk("frame_err", 32'(frame_err), 32'(e_fe));
            chk("data", 32'(data), 32'(e_data));
            chk("moving", 32'(moving), 32'(m_moving));
            chk("status_valid", 32'(status_valid), 32'(e_sv));
            chk("busy", 32'(busy), 32'(e_busy));
            if (data_valid) dv_cnt = dv_cnt + 1;
            if (frame_err) fe_cnt = fe_cnt + 1;
            if (e_dv) begin
                m_data = e_data;
                if (e_data == 8'h4D || e_data == 8'h53) begin
                    m_moving = (e_data == 8'h4D);
                    have_st  = 1'b1;
                    st_d     = k;
                end
            end
        end
    end

    task automatic model_reset();
        evq.delete();
        win_valid = 1'b0;
        m_data    = 8'h00;
        m_moving  = 1'b0;
        have_st   = 1'b0;
    endtask

    // Drives one 8N1 frame starting right after a clock edge; rx is left at the stop level.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        ev_t e;
        e.cyc = cyc + 3 + HALF + 9 * DIV;
        e.ok  = stop_ok;
        e.b   = b;
        evq.push_back(e);
        last_d    = e.cyc;
        win_from  = cyc + 3;
        win_to    = cyc + 2 + HALF + 9 * DIV;
        win_valid = 1'b1;
        rx = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(DIV);
        end
        rx = stop_ok;
        tick(DIV);
    endtask

    task automatic glitch(input int g);
        win_from  = cyc + 3;
        win_to    = cyc + 2 + HALF;
        win_valid = 1'b1;
        rx = 1'b0;
        tick(g);
        rx = 1'b1;
        tick(2 * DIV);
    endtask

    typedef struct {
        logic [7:0] b;
        bit         stop_ok;
        int         gap;
        logic [7:0] e_data;
        bit         e_moving;
        bit         e_sv;
    } vec_t;

    vec_t vt[10];

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int sv_dv;
        int sv_fe;
        int n0;
        logic [7:0] rb;
        bit rok;
        int gap;

        vt[0] = '{8'h4D, 1'b1, 0,    8'h4D, 1'b1, 1'b1};
        vt[1] = '{8'h53, 1'b1, 0,    8'h53, 1'b0, 1'b1};
        vt[2] = '{8'hA5, 1'b1, 200,  8'hA5, 1'b0, 1'b1};
        vt[3] = '{8'h4D, 1'b0, 100,  8'hA5, 1'b0, 1'b0};
        vt[4] = '{8'h4D, 1'b1, 1200, 8'h4D, 1'b1, 1'b1};
        vt[5] = '{8'h31, 1'b1, 0,    8'h31, 1'b1, 1'b0};
        vt[6] = '{8'h53, 1'b1, 0,    8'h53, 1'b0, 1'b1};
        vt[7] = '{8'h4D, 1'b1, 50,   8'h4D, 1'b1, 1'b1};
        vt[8] = '{8'h00, 1'b1, 0,    8'h00, 1'b1, 1'b1};
        vt[9] = '{8'hFF, 1'b1, 0,    8'hFF, 1'b1, 1'b0};

        rst_n = 1'b0;
        rx    = 1'b1;
        tick(3);
        chk("reset_data", 32'(data), 32'h0);
        chk("reset_data_valid", 32'(data_valid), 32'h0);
        chk("reset_frame_err", 32'(frame_err), 32'h0);
        chk("reset_moving", 32'(moving), 32'h0);
        chk("reset_status_valid", 32'(status_valid), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        tick(2);
        mon_en = 1'b1;
        tick(5);

        for (int i = 0; i < 10; i++) begin
            send_frame(vt[i].b, vt[i].stop_ok);
            chk($sformatf("vec%0d_data", i), 32'(data), 32'(vt[i].e_data));
            chk($sformatf("vec%0d_moving", i), 32'(moving), 32'(vt[i].e_moving));
            chk($sformatf("vec%0d_status_valid", i), 32'(status_valid), 32'(vt[i].e_sv));
            rx = 1'b1;
            tick(vt[i].gap);
        end
        tick(DIV);

        // Framing error followed by a held-low break line.
        sv_dv = dv_cnt;
        sv_fe = fe_cnt;
        send_frame(8'h4D, 1'b0);
        tick(3 * DIV);
        chk("break_busy", 32'(busy), 32'h0);
        chk("break_fe_count", 32'(fe_cnt - sv_fe), 32'd1);
        chk("break_dv_count", 32'(dv_cnt - sv_dv), 32'd0);
        chk("break_data", 32'(data), 32'hFF);
        rx = 1'b1;
        tick(DIV);
        send_frame(8'h53, 1'b1);
        chk("after_break_data", 32'(data), 32'h53);
        chk("after_break_moving", 32'(moving), 32'h0);
        rx = 1'b1;
        tick(DIV);

        // Short low glitch aborts in START.
        sv_dv = dv_cnt;
        sv_fe = fe_cnt;
        glitch(20);
        chk("glitch_busy", 32'(busy), 32'h0);
        chk("glitch_dv_count", 32'(dv_cnt - sv_dv), 32'd0);
        chk("glitch_fe_count", 32'(fe_cnt - sv_fe), 32'd0);

        // Timeout boundary relative to the data_valid cycle.
        send_frame(8'h4D, 1'b1);
        rx = 1'b1;
        while (cyc < last_d + TMO - 1) tick(1);
        chk("timeout_before", 32'(status_valid), 32'h1);
        tick(1);
        chk("timeout_at", 32'(status_valid), 32'h0);
        chk("timeout_moving", 32'(moving), 32'h1);
        tick(DIV);

        // Reset in the middle of bit 4.
        n0 = cyc;
        rb = 8'h96;
        win_from  = n0 + 3;
        win_to    = n0 + 2 + HALF + 9 * DIV;
        win_valid = 1'b1;
        rx = 1'b0;
        tick(DIV);
        for (int i = 0; i < 4; i++) begin
            rx = rb[i];
            tick(DIV);
        end
        rx = rb[4];
        tick(DIV / 2);
        rst_n = 1'b0;
        rx    = 1'b1;
        model_reset();
        #1;
        chk("midreset_data", 32'(data), 32'h0);
        chk("midreset_moving", 32'(moving), 32'h0);
        chk("midreset_busy", 32'(busy), 32'h0);
        chk("midreset_status_valid", 32'(status_valid), 32'h0);
        tick(4);
        rst_n = 1'b1;
        tick(10);
        send_frame(8'h53, 1'b1);
        chk("postreset_data", 32'(data), 32'h53);
        chk("postreset_moving", 32'(moving), 32'h0);
        chk("postreset_status_valid", 32'(status_valid), 32'h1);
        rx = 1'b1;
        tick(DIV);

        // Randomized traffic against the scoreboard.
        for (int i = 0; i < 25; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                glitch(int'($urandom_range(1, HALF - 1)));
            end else begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3: rb = 8'h4D;
                    4, 5, 6:    rb = 8'h53;
                    default:    rb = 8'($urandom_range(0, 255));
                endcase
                rok = ($urandom_range(0, 9) != 0);
                send_frame(rb, rok);
                if (!rok) gap = int'($urandom_range(DIV, 3 * DIV));
                else if ($urandom_range(0, 2) == 0) gap = 0;
                else gap = int'($urandom_range(1, 1300));
                rx = 1'b1;
                tick(gap);
            end
        end
        tick(2 * DIV);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
